mult_share_arbiter: RTL and testbench

- Shares one signed 8x8 array multiplier datapath between NUM_REQ independent requesters using round-robin arbitration.
- Sequences each operation through operand capture, compute, and result hold.
- Returns a registered signed product tagged with the requester index over a valid/ready response channel.
- Sits between the DSP-side requesters and the single multiplier instance, so no requester needs its own multiplier.

---
 rtl/mult_share_arbiter.sv | 135 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one signed WIDTH x WIDTH array multiplier
// between NUM_REQ requesters. Each operation is captured, multiplied and then
// held on a valid/ready response channel tagged with the owning requester index.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [2*WIDTH-1:0]         resp_product
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e               state_q;
  logic [ID_W-1:0]      last_q;
  logic [WIDTH-1:0]     op_a_q;
  logic [WIDTH-1:0]     op_b_q;
  logic [ID_W-1:0]      op_id_q;

  logic                 grant_valid;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      scan_idx;
  logic                 accept;
  logic [WIDTH-1:0]     grant_a;
  logic [WIDTH-1:0]     grant_b;
  logic [2*WIDTH-1:0]   mul_result;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   b_ext;
  logic [2*WIDTH-1:0]   pp;

  // Round-robin search starting just after the last granted requester, with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(last_q) + int'(k)) % int'(NUM_REQ));
      if (!grant_valid && req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // A new operation can only be taken when the datapath is free: idle, or the held
  // result is being consumed this very cycle.
  always_comb begin
    accept    = grant_valid &&
                ((state_q == StIdle) || ((state_q == StDone) && resp_ready));
    req_ready = '0;
    if (accept) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end
    grant_a = req_a[int'(grant_idx)*int'(WIDTH) +: WIDTH];
    grant_b = req_b[int'(grant_idx)*int'(WIDTH) +: WIDTH];
  end

  // Shift-and-add array multiplier on sign-extended operands; keeping the low
  // 2*WIDTH bits of the sum gives the exact two's-complement product.
  always_comb begin
    a_ext      = {{WIDTH{op_a_q[WIDTH-1]}}, op_a_q};
    b_ext      = {{WIDTH{op_b_q[WIDTH-1]}}, op_b_q};
    mul_result = '0;
    pp         = '0;
    for (int unsigned i = 0; i < 2*WIDTH; i++) begin
      pp         = b_ext[i] ? (a_ext << i) : '0;
      mul_result = mul_result + pp;
    end
  end

  // Operation sequencer: capture, multiply, hold result until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_product <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            op_a_q  <= grant_a;
            op_b_q  <= grant_b;
            op_id_q <= grant_idx;
            last_q  <= grant_idx;
            state_q <= StMul;
          end
        end
        StMul: begin
          resp_product <= mul_result;
          resp_id      <= op_id_q;
          resp_valid   <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (grant_valid) begin
              // Back-to-back: response and next request handshake on the same edge.
              op_a_q  <= grant_a;
              op_b_q  <= grant_b;
              op_id_q <= grant_idx;
              last_q  <= grant_idx;
              state_q <= StMul;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with NUM_REQ=4, WIDTH=8.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_product;

  int checks;
  int errors;

  mult_share_arbiter #(
    .NUM_REQ(4),
    .WIDTH  (8),
    .ID_W   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_product(resp_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
  endtask

  // One isolated operation from requester id, with resp_ready held high.
  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    #1;
    chk("single_ready", 16'(req_ready), 16'(4'b0001 << id));
    tick;
    req_valid[id] = 1'b0;
    #1;
    chk("single_mul_valid", 16'(resp_valid), 16'd0);
    chk("single_mul_ready", 16'(req_ready), 16'd0);
    tick;
    chk("single_done_valid", 16'(resp_valid), 16'd1);
    chk("single_product", resp_product, exp);
    chk("single_id", 16'(resp_id), 16'(id));
    tick;
    chk("single_released", 16'(resp_valid), 16'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", 16'(resp_valid), 16'd0);
    chk("rst_id", 16'(resp_id), 16'd0);
    chk("rst_product", resp_product, 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd0);
    rst_n = 1'b1;
    tick;

    // Corner products from requester 0.
    single(0, 8'h80, 8'h80, 16'd16384);
    single(0, 8'h80, 8'h7f, 16'(-16256));
    single(0, 8'h00, 8'(-5), 16'd0);

    // All four requesters valid from reset: grants 0..3, back-to-back.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_op(k, 8'(k + 1), 8'(-3));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 16'(req_ready), 16'(4'b0001 << k));
      tick;
      req_valid[k] = 1'b0;
      #1;
      chk("rr_mul_valid", 16'(resp_valid), 16'd0);
      tick;
      chk("rr_done_valid", 16'(resp_valid), 16'd1);
      chk("rr_product", resp_product, 16'(-3 * (k + 1)));
      chk("rr_id", 16'(resp_id), 16'(k));
    end
    tick;
    chk("rr_idle", 16'(resp_valid), 16'd0);

    // Stall in DONE: result held, new request waits, then granted on release.
    resp_ready = 1'b0;
    set_op(2, 8'd5, 8'd6);
    req_valid = 4'b0100;
    #1;
    chk("stall_grant2", 16'(req_ready), 16'b0100);
    tick;
    req_valid = 4'b0000;
    tick;
    set_op(0, 8'd2, 8'd2);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 16'(resp_valid), 16'd1);
      chk("stall_product", resp_product, 16'd30);
      chk("stall_id", 16'(resp_id), 16'd2);
      chk("stall_ready", 16'(req_ready), 16'd0);
      tick;
    end
    resp_ready = 1'b1;
    #1;
    chk("release_ready", 16'(req_ready), 16'b0001);
    tick;
    req_valid = 4'b0000;
    #1;
    chk("release_valid_drop", 16'(resp_valid), 16'd0);
    tick;
    chk("release_product", resp_product, 16'd4);
    chk("release_id", 16'(resp_id), 16'd0);
    tick;

    // Fairness between 1 and 3 after requester 1 was last served.
    single(1, 8'd1, 8'd1, 16'd1);
    set_op(1, 8'd3, 8'd4);
    set_op(3, 8'(-2), 8'd5);
    req_valid = 4'b1010;
    #1;
    chk("fair_ready_a", 16'(req_ready), 16'b1000);
    tick;
    tick;
    chk("fair_product_a", resp_product, 16'(-10));
    chk("fair_id_a", 16'(resp_id), 16'd3);
    chk("fair_ready_b", 16'(req_ready), 16'b0010);
    tick;
    tick;
    chk("fair_product_b", resp_product, 16'd12);
    chk("fair_id_b", 16'(resp_id), 16'd1);
    chk("fair_ready_c", 16'(req_ready), 16'b1000);
    tick;
    req_valid = 4'b0000;
    tick;
    chk("fair_id_c", 16'(resp_id), 16'd3);
    tick;

    // Reset during MUL discards the operation.
    set_op(2, 8'd9, 8'd9);
    req_valid = 4'b0100;
    tick;
    req_valid = 4'b0000;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mulrst_valid", 16'(resp_valid), 16'd0);
    chk("mulrst_product", resp_product, 16'd0);
    chk("mulrst_id", 16'(resp_id), 16'd0);
    tick;
    tick;
    chk("mulrst_no_stale", 16'(resp_valid), 16'd0);
    set_op(0, 8'd0, 8'(-5));
    req_valid = 4'b0101;
    #1;
    chk("mulrst_prio0", 16'(req_ready), 16'b0001);
    tick;
    req_valid = 4'b0000;
    tick;
    chk("mulrst_zero", resp_product, 16'd0);
    tick;

    // Back-to-back from requester 2.
    set_op(2, 8'd7, 8'(-9));
    req_valid = 4'b0100;
    #1;
    chk("b2b_ready0", 16'(req_ready), 16'b0100);
    for (int n = 0; n < 3; n++) begin
      tick;
      chk("b2b_mul_valid", 16'(resp_valid), 16'd0);
      tick;
      chk("b2b_valid", 16'(resp_valid), 16'd1);
      chk("b2b_product", resp_product, 16'(-63));
      chk("b2b_id", 16'(resp_id), 16'd2);
      chk("b2b_ready", 16'(req_ready), 16'b0100);
    end
    req_valid = 4'b0000;
    tick;
    tick;
    chk("b2b_idle", 16'(resp_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
